// File: rtl/mmio_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_uart_tx_pkg
//  Description : Shared definitions for the memory-mapped UART transmitter.
//                Contains the register offsets, STATUS bit positions, the FSM
//                state encodings, the default base address and a helper that
//                packs the STATUS word.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package mmio_uart_tx_pkg;

    // Default peripheral base address; bits [3:0] must stay zero.
    localparam logic [31:0] C_DEFAULT_BASE_ADDR = 32'h0000_1000;

    // Byte offsets of the registers inside the 16-byte window.
    localparam logic [3:0] C_UART_TXDATA = 4'h0;
    localparam logic [3:0] C_UART_STATUS = 4'h4;

    // Word index (a[3:2]) of each register; a[1:0] is ignored by the decoder.
    localparam logic [1:0] C_REG_TXDATA = C_UART_TXDATA[3:2];
    localparam logic [1:0] C_REG_STATUS = C_UART_STATUS[3:2];

    // STATUS bit positions.
    localparam int C_STAT_FULL      = 0;
    localparam int C_STAT_EMPTY     = 1;
    localparam int C_STAT_BUSY      = 2;
    localparam int C_STAT_OVF       = 3;
    localparam int C_STAT_COUNT_LSB = 4;
    localparam int C_STAT_COUNT_W   = 5;

    // FSM state encodings.
    localparam logic [1:0] C_ST_IDLE  = 2'd0;
    localparam logic [1:0] C_ST_START = 2'd1;
    localparam logic [1:0] C_ST_DATA  = 2'd2;
    localparam logic [1:0] C_ST_STOP  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = C_ST_IDLE,
        ST_START = C_ST_START,
        ST_DATA  = C_ST_DATA,
        ST_STOP  = C_ST_STOP
    } uart_state_t;

    // Assemble the STATUS word; unused bits read as zero.
    function automatic logic [31:0] pack_status(
        input logic                      full,
        input logic                      empty,
        input logic                      busy,
        input logic                      ovf,
        input logic [C_STAT_COUNT_W-1:0] count
    );
        logic [31:0] w_word;
        w_word = '0;
        w_word[C_STAT_FULL]  = full;
        w_word[C_STAT_EMPTY] = empty;
        w_word[C_STAT_BUSY]  = busy;
        w_word[C_STAT_OVF]   = ovf;
        w_word[C_STAT_COUNT_LSB +: C_STAT_COUNT_W] = count;
        return w_word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_uart_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_uart_tx_if
//  Description : Core data-bus view seen by the UART transmitter. Carries the
//                same signals the core presents to dmem.
//  Signals     : we  - write strobe (MemWrite)
//                a   - byte address (ALU result)
//                wd  - write data
//                rd  - read data from the peripheral (combinational)
//                sel - peripheral address decode hit (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
interface mmio_uart_tx_if;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        sel;

    // The core drives the request side and consumes read data + decode.
    modport master (
        output we, a, wd,
        input  rd, sel
    );

    // The peripheral consumes the request and returns read data + decode.
    modport slave (
        input  we, a, wd,
        output rd, sel
    );
endinterface
`default_nettype wire

// File: rtl/mmio_uart_tx_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_uart_tx_sync_fifo
//  Description : Generic single-clock FIFO (the sync_fifo building block),
//                circular buffer with wrapping read/write pointers and a
//                separate occupancy counter. Reusable for a receive path.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_push/i_push_data - write request and data
//                i_pop           - read request (ignored when empty)
//                o_pop_data      - head entry (valid when not empty)
//                o_full/o_empty  - occupancy flags
//                o_count         - entries stored, 0..DEPTH
//                o_push_drop     - push rejected this cycle (full, no pop)
//  Revision    : 1.0 - initial release
// ============================================================================
module mmio_uart_tx_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8          // power of two, 2..16
) (
    input  wire logic                         clk,
    input  wire logic                         rst,
    input  wire logic                         i_push,
    input  wire logic [WIDTH-1:0]             i_push_data,
    input  wire logic                         i_pop,
    output logic      [WIDTH-1:0]             o_pop_data,
    output logic                              o_full,
    output logic                              o_empty,
    output logic      [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                              o_push_drop
);

    localparam int                 c_PTR_W     = $clog2(DEPTH);
    localparam int                 c_CNT_W     = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_full   = (r_count == c_DEPTH_CNT);
    assign w_empty  = (r_count == '0);
    assign w_do_pop = i_pop && !w_empty;
    // A pop in the same cycle frees the slot the push lands in, so a push
    // while full is still accepted when the head leaves on this edge.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    // Storage kept out of the reset domain so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_pop_data  = r_mem[r_rd_ptr];
    assign o_full      = w_full;
    assign o_empty     = w_empty;
    assign o_count     = r_count;
    assign o_push_drop = i_push && !w_do_push;

endmodule
`default_nettype wire

// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_uart_tx
//  Description : Memory-mapped 8N1 UART transmitter sitting beside dmem on
//                the core data bus. Bytes written to TXDATA are queued in a
//                small FIFO and shifted out LSB first on `tx`.
//                Register map (offset a[3:2]):
//                  0x0 TXDATA  write: push wd[7:0]; read: 0
//                  0x4 STATUS  read : [0] full [1] empty [2] busy
//                                     [3] overflow (sticky) [8:4] count
//                              write: wd[3]=1 clears overflow
//                  0x8/0xC     read 0, writes ignored
//  Ports       : clk   - system clock
//                reset - synchronous, active-high reset
//                bus   - data-bus slave (we, a, wd in; rd, sel out)
//                tx    - UART serial output, idle high, registered
//  Revision    : 1.0 - initial release
// ============================================================================
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 868,   // >= 2
    parameter int          FIFO_DEPTH   = 8,     // power of two, 2..16
    parameter logic [31:0] BASE_ADDR    = C_DEFAULT_BASE_ADDR
) (
    input  wire logic          clk,
    input  wire logic          reset,
    mmio_uart_tx_if.slave      bus,
    output logic               tx
);

    localparam int                  c_CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int                  c_BAUD_W   = $clog2(CLKS_PER_BIT);
    localparam logic [c_BAUD_W-1:0] c_BAUD_MAX = c_BAUD_W'(CLKS_PER_BIT - 1);

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic       w_sel;
    logic [1:0] w_reg;
    logic       w_wr;
    logic       w_push;
    logic       w_ovf_clr;

    assign w_sel     = (bus.a[31:4] == BASE_ADDR[31:4]);
    assign w_reg     = bus.a[3:2];
    assign w_wr      = bus.we && w_sel;
    assign w_push    = w_wr && (w_reg == C_REG_TXDATA);
    assign w_ovf_clr = w_wr && (w_reg == C_REG_STATUS) && bus.wd[C_STAT_OVF];

    // Byte-lane bits and the rest of the write word carry no meaning here.
    logic w_unused;
    assign w_unused = &{1'b0, bus.a[1:0], bus.wd[31:8]};

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]         w_head;
    logic               w_full;
    logic               w_empty;
    logic [c_CNT_W-1:0] w_count;
    logic               w_push_drop;
    logic               w_pop;

    uart_state_t r_state;

    // Only the idle FSM takes the head, so a byte pushed on edge N is
    // popped no earlier than edge N+1.
    assign w_pop = (r_state == ST_IDLE) && !w_empty;

    mmio_uart_tx_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (reset),
        .i_push      (w_push),
        .i_push_data (bus.wd[7:0]),
        .i_pop       (w_pop),
        .o_pop_data  (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count),
        .o_push_drop (w_push_drop)
    );

    // ------------------------------------------------------------------
    // Sticky overflow flag. Set and clear live at different offsets, so
    // they never coincide.
    // ------------------------------------------------------------------
    logic r_ovf;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_push_drop) begin
            r_ovf <= 1'b1;
        end else if (w_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM with baud counter. tx comes straight from a flop and
    // is updated together with each state transition, so the line level
    // always matches the state the FSM has just entered.
    // ------------------------------------------------------------------
    logic [c_BAUD_W-1:0] r_baud;
    logic [2:0]          r_bit_idx;
    logic [7:0]          r_shift;
    logic                r_tx;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tx <= 1'b1;
                    if (!w_empty) begin
                        r_shift <= w_head;
                        r_baud  <= c_BAUD_MAX;
                        r_tx    <= 1'b0;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (r_baud == '0) begin
                        r_baud    <= c_BAUD_MAX;
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= ST_DATA;
                    end else begin
                        r_baud <= r_baud - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_baud == '0) begin
                        r_baud <= c_BAUD_MAX;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= ST_STOP;
                        end else begin
                            // Next bit is shift[1] before the shift lands.
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud - 1'b1;
                    end
                end
                ST_STOP: begin
                    if (r_baud == '0) begin
                        r_tx    <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_baud <= r_baud - 1'b1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx = r_tx;

    // ------------------------------------------------------------------
    // Read path: combinational from the address, zero when not selected.
    // ------------------------------------------------------------------
    logic [31:0] w_status;

    assign w_status = pack_status(w_full, w_empty, (r_state != ST_IDLE), r_ovf,
                                  C_STAT_COUNT_W'(w_count));

    assign bus.sel = w_sel;
    assign bus.rd  = (w_sel && (w_reg == C_REG_STATUS)) ? w_status : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mmio_uart_tx
//  Description : Self-checking bench for mmio_uart_tx (CLKS_PER_BIT=4,
//                FIFO_DEPTH=8). A frame-level reference model predicts the
//                line level and STATUS every cycle; a line receiver decodes
//                frames and matches them against the bytes the model says
//                were started. Register/decode vectors come from a table.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_uart_tx;

    localparam int C     = 4;          // clocks per bit
    localparam int D     = 8;          // FIFO depth
    localparam int FRAME = 10 * C;     // cycles a frame keeps the FSM busy

    logic clk;
    logic reset;
    logic tx;

    mmio_uart_tx_if bus ();

    mmio_uart_tx #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (D),
        .BASE_ADDR    (32'h0000_1000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .tx    (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [31:0] last_rd;
    logic        last_sel;
    logic        last_tx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: bytes waiting, the edge the current frame started,
    // and the byte being sent. Line level is derived from elapsed cycles.
    // ------------------------------------------------------------------
    logic [7:0] q_m[$];
    logic [7:0] sent_log[$];
    bit         m_have;
    int         m_pop_edge;
    logic [7:0] m_cur;
    bit         m_ovf;

    // Line receiver state.
    bit         rx_busy;
    int         rx_start;
    logic [7:0] rx_sh;
    logic       rx_prev;
    logic [7:0] rx_got[$];
    int         rx_starts[$];

    function automatic logic m_busy();
        return m_have && (cyc < m_pop_edge + FRAME);
    endfunction

    function automatic logic m_tx();
        int k;
        int slot;
        if (!m_busy()) return 1'b1;
        k    = cyc - m_pop_edge;
        slot = k / C;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return m_cur[slot-1];
    endfunction

    function automatic logic [31:0] m_status();
        return {23'd0, 5'(q_m.size()), m_ovf, m_busy(), (q_m.size() == 0), (q_m.size() == D)};
    endfunction

    task automatic model_reset();
        q_m.delete();
        sent_log.delete();
        m_have  = 1'b0;
        m_ovf   = 1'b0;
        rx_busy = 1'b0;
        rx_prev = 1'b1;
    endtask

    task automatic model_edge(input bit push, input logic [7:0] data, input bit clr);
        bit pop;
        bit full_pre;
        pop      = (q_m.size() > 0) && (!m_have || cyc >= m_pop_edge + FRAME + 1);
        full_pre = (q_m.size() == D);
        if (pop) begin
            m_cur      = q_m.pop_front();
            m_have     = 1'b1;
            m_pop_edge = cyc;
            sent_log.push_back(m_cur);
        end
        if (push) begin
            if (!full_pre || pop) q_m.push_back(data);
            else                  m_ovf = 1'b1;
        end
        if (clr) m_ovf = 1'b0;
    endtask

    task automatic rx_step();
        int k;
        if (!rx_busy) begin
            if (rx_prev === 1'b1 && tx === 1'b0) begin
                rx_busy  = 1'b1;
                rx_start = cyc;
                rx_starts.push_back(cyc);
            end
        end else begin
            k = cyc - rx_start;
            if (k >= C + C/2 && k < 9*C && ((k - C/2) % C) == 0)
                rx_sh[(k - C/2)/C - 1] = tx;
            if (k == 9*C + C/2) begin
                chk("rx_stop_bit", {31'd0, tx}, 32'd1);
                rx_got.push_back(rx_sh);
                if (sent_log.size() == 0) chk("rx_unexpected_byte", {24'd0, rx_sh}, 32'hFFFF_FFFF);
                else                      chk("rx_byte", {24'd0, rx_sh}, {24'd0, sent_log.pop_front()});
                rx_busy = 1'b0;
            end
        end
        rx_prev = tx;
    endtask

    // One bus cycle: drive, check combinational outputs, take the edge,
    // update the model, then check the registered line level.
    task automatic tick(input logic we_i, input logic [31:0] a_i, input logic [31:0] wd_i);
        logic exp_sel;
        bus.we = we_i;
        bus.a  = a_i;
        bus.wd = wd_i;
        #1;
        exp_sel  = (a_i[31:4] == 28'h000_0100);
        last_rd  = bus.rd;
        last_sel = bus.sel;
        chk("sel_decode", {31'd0, bus.sel}, {31'd0, exp_sel});
        if (exp_sel && a_i[3:2] == 2'd1) chk("rd_status", bus.rd, m_status());
        else                             chk("rd_zero", bus.rd, 32'd0);
        @(posedge clk);
        cyc++;
        if (reset) model_reset();
        else model_edge(we_i && exp_sel && a_i[3:2] == 2'd0, wd_i[7:0],
                        we_i && exp_sel && a_i[3:2] == 2'd1 && wd_i[3]);
        #1;
        last_tx = tx;
        chk("tx_line", {31'd0, tx}, {31'd0, m_tx()});
        rx_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 32'h0000_1004, 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_sel;
    } vec_t;

    vec_t vecs[13];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 32'h0000_1004, 32'h0,  32'h2, 1'b1};
        vecs[1]  = '{1'b0, 32'h0000_1000, 32'h0,  32'h0, 1'b1};
        vecs[2]  = '{1'b0, 32'h0000_1008, 32'h0,  32'h0, 1'b1};
        vecs[3]  = '{1'b0, 32'h0000_100C, 32'h0,  32'h0, 1'b1};
        vecs[4]  = '{1'b0, 32'h0000_1007, 32'h0,  32'h2, 1'b1};
        vecs[5]  = '{1'b0, 32'h0000_2000, 32'h0,  32'h0, 1'b0};
        vecs[6]  = '{1'b1, 32'h0000_2000, 32'h55, 32'h0, 1'b0};
        vecs[7]  = '{1'b1, 32'h0000_1008, 32'hFF, 32'h0, 1'b1};
        vecs[8]  = '{1'b1, 32'h0000_100C, 32'hFF, 32'h0, 1'b1};
        vecs[9]  = '{1'b0, 32'h0000_0FFC, 32'h0,  32'h0, 1'b0};
        vecs[10] = '{1'b0, 32'h0000_1014, 32'h0,  32'h0, 1'b0};
        vecs[11] = '{1'b1, 32'h0000_1004, 32'h8,  32'h2, 1'b1};
        vecs[12] = '{1'b0, 32'h0000_1004, 32'h0,  32'h2, 1'b1};

        // Reset held for two edges.
        bus.we = 1'b0; bus.a = 32'h0000_1004; bus.wd = 32'd0;
        reset  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        chk("reset_tx", {31'd0, tx}, 32'd1);

        // Register map and decode vectors.
        for (int i = 0; i < 13; i++) begin
            tick(vecs[i].we, vecs[i].a, vecs[i].wd);
            chk($sformatf("vec%0d_rd", i), last_rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_sel", i), {31'd0, last_sel}, {31'd0, vecs[i].exp_sel});
        end
        idle(100);
        chk("reset_idle_rx", rx_got.size(), 0);

        // Single byte 0x55.
        tick(1'b1, 32'h0000_1000, 32'h55);
        chk("write_edge_tx", {31'd0, last_tx}, 32'd1);
        tick(1'b0, 32'h0000_1004, 32'd0);
        chk("start_bit_tx", {31'd0, last_tx}, 32'd0);
        tick(1'b0, 32'h0000_1004, 32'd0);
        chk("busy_status", last_rd, 32'h6);
        idle(45);
        chk("single_done_status", last_rd, 32'h2);
        chk("single_rx_count", rx_got.size(), 1);
        chk("single_rx_byte", {24'd0, rx_got[0]}, 32'h55);

        // Back-to-back frames.
        rx_got.delete(); rx_starts.delete();
        tick(1'b1, 32'h0000_1000, 32'hA5);
        tick(1'b1, 32'h0000_1000, 32'h3C);
        idle(100);
        chk("b2b_rx_count", rx_got.size(), 2);
        chk("b2b_byte0", {24'd0, rx_got[0]}, 32'hA5);
        chk("b2b_byte1", {24'd0, rx_got[1]}, 32'h3C);
        chk("b2b_spacing", rx_starts[1] - rx_starts[0], 41);

        // Fill, overflow, clear, then push on a pop edge while full.
        rx_got.delete();
        for (int i = 0; i < 9; i++) tick(1'b1, 32'h0000_1000, 32'h10 + i);
        tick(1'b0, 32'h0000_1004, 32'd0);
        chk("full_status", last_rd, 32'h85);
        tick(1'b1, 32'h0000_1000, 32'h99);
        tick(1'b0, 32'h0000_1004, 32'd0);
        chk("overflow_status", last_rd, 32'h8D);
        tick(1'b1, 32'h0000_1004, 32'h8);
        tick(1'b0, 32'h0000_1004, 32'd0);
        chk("ovf_cleared_status", last_rd, 32'h85);
        for (int n = 0; n < 100 && (cyc + 1 != m_pop_edge + FRAME + 1); n++)
            tick(1'b0, 32'h0000_1004, 32'd0);
        chk("pop_edge_found", cyc + 1, m_pop_edge + FRAME + 1);
        tick(1'b1, 32'h0000_1000, 32'h77);
        tick(1'b0, 32'h0000_1004, 32'd0);
        chk("push_on_pop_status", last_rd, 32'h85);
        idle(420);
        chk("drain_status", last_rd, 32'h2);
        chk("fill_rx_count", rx_got.size(), 10);
        for (int i = 0; i < 9; i++)
            chk($sformatf("fill_byte%0d", i), {24'd0, rx_got[i]}, 32'h10 + i);
        chk("fill_byte9", {24'd0, rx_got[9]}, 32'h77);

        // Off-decode write, reserved read, reset mid-frame.
        rx_got.delete();
        tick(1'b1, 32'h0000_2000, 32'h5A);
        idle(50);
        chk("offdecode_no_frame", rx_got.size(), 0);
        tick(1'b0, 32'h0000_1008, 32'd0);
        chk("reserved_read", last_rd, 32'd0);
        tick(1'b1, 32'h0000_1000, 32'hF0);
        tick(1'b1, 32'h0000_1000, 32'h0F);
        idle(14);
        reset = 1'b1;
        tick(1'b0, 32'h0000_1004, 32'd0);
        reset = 1'b0;
        chk("reset_mid_tx", {31'd0, last_tx}, 32'd1);
        tick(1'b0, 32'h0000_1004, 32'd0);
        chk("reset_mid_status", last_rd, 32'h2);
        idle(100);
        chk("reset_mid_no_frames", rx_got.size(), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 8)       tick(1'b1, 32'h0000_1000, $urandom);
            else if (r < 10) tick(1'b1, 32'h0000_1004, $urandom);
            else if (r < 12) tick(1'b1, 32'h0000_2000 | ($urandom & 32'hF), $urandom);
            else             tick(1'b0, 32'h0000_1000 | 32'($urandom_range(0, 15)), 32'd0);
        end
        idle(9 * 41 + 50);
        chk("random_drain_empty", {31'd0, last_rd[1]}, 32'd1);
        chk("random_all_received", sent_log.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter on the core's data bus, in parallel with dmem. It uses the same bus signals as dmem: MemWrite, the ALU address, WriteData and ReadData. Stores written bytes in a small TX FIFO and serialises them 8N1 on a pin, giving the RV32I program a console path beyond the 8 LEDs. Top-level decodes `sel` to mux `rd` into the core's read-data path instead of dmem.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); must be >= 2
FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..16
BASE_ADDR, 32'h0000_1000, peripheral base; bits [3:0] must be zero

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
we  input  1  bus write strobe (core MemWrite)
a  input  32  bus byte address (core ALU result)
wd  input  32  bus write data
rd  output  32  read data, combinational from `a`
sel  output  1  combinational; 1 when a[31:4] == BASE_ADDR[31:4]
tx  output  1  UART serial output, idle high

Behaviour:
- Clocking/reset: one clock `clk`; `reset` is synchronous and active-high.
- Register map (offset = a[3:2]; a[1:0] ignored):
  - 0x0 TXDATA, write-only: push wd[7:0]. Reads return 0.
  - 0x4 STATUS, read: [0] full, [1] empty, [2] busy (FSM not IDLE), [3] overflow (sticky), [8:4] FIFO count, other bits 0. Write with wd[3]=1 clears overflow.
  - 0x8, 0xC: reads return 0; writes are ignored.
- rd is combinational, with zero added latency, matching dmem read timing. When sel=0, rd = 0.
- Writes take effect on the rising edge where we=1 and sel=1.
- Reset values: tx=1, FIFO empty (count 0), overflow=0, FSM in IDLE, baud counter 0, bit index 0.
- FIFO:
  - Circular buffer with read/write pointers of clog2(FIFO_DEPTH) bits that wrap modulo depth.
  - Count is held in a separate register, range 0..FIFO_DEPTH.
  - Push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the push is dropped and overflow is set to 1.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Simultaneous overflow-set and overflow-clear write: impossible (different offsets).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO is non-empty: pop the head into the shift register, load the baud counter with CLKS_PER_BIT-1, go to START. The pop happens on the edge after the push edge at the earliest.
  - START: tx=0 for CLKS_PER_BIT cycles. When the counter reaches 0, reload it, set bit index 0, go to DATA.
  - DATA: tx = shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles, then the register shifts right. After bit index 7 expires, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE. There are no extra idle cycles: if the FIFO is non-empty, the next START begins on the next cycle. Back-to-back frame period is therefore 10*CLKS_PER_BIT + 1 cycles.
- tx is registered (driven from a flop) to be glitch-free.
- Latency: push at edge N; tx falls after edge N+1 if the FSM was IDLE.
- Reset mid-frame: tx returns to 1 immediately after the reset edge, the FIFO is flushed, and the frame in progress is lost.

Decomposition:
- Shared package/header (config.vh style): register offsets (UART_TXDATA=0, UART_STATUS=4), STATUS bit positions, FSM state encodings (2-bit localparams), default BASE_ADDR.
- One sub-module: `sync_fifo` (parameterised width and depth; push, pop, full, empty, count), reusable for a later RX path.
- FSM, baud counter and bus decode live in `mmio_uart_tx`.

Test Plan:
- Reset: assert reset for 2 cycles, then read 0x1004 -> rd=32'h0000_0002 (empty), tx=1 and stays 1 for 100 cycles.
- Single byte (CLKS_PER_BIT=4): write 0x55 to 0x1000 -> tx low 4 cycles starting one edge after the write, then 0,1 alternating per 4 cycles beginning with 1 (LSB first), then high 4 cycles. Busy=1 during the frame; STATUS returns to 0x2 afterwards.
- Back-to-back: write 0xA5, 0x3C on consecutive cycles -> two frames, second start bit exactly 41 cycles after the first (CLKS_PER_BIT=4). Sampled bytes equal 0xA5, then 0x3C.
- Full/overflow: with FSM busy, write 9 bytes quickly (DEPTH=8; first byte already popped) -> count reaches 8, full=1. Next write is dropped, overflow=1. Writing 0x8 to 0x1004 clears overflow. All 9 accepted bytes are transmitted in order.
- Push at full with simultaneous pop: fill FIFO while STOP is ending, then write on the pop edge -> byte accepted, count stays 8, overflow stays 0.
- Decode/reset mid-frame: write to 0x2000 -> sel=0, no frame. Read 0x1008 -> 0. Assert reset mid DATA bit -> tx=1 on the next cycle, STATUS=0x2, no further frames.
